// File: rtl/axi_stream_insert_header_if.sv
// Bundle of the payload, output and header channels of the AXI-Stream header inserter.
// The slave modport is the inserter's view; master is the view of whatever drives it.
interface axi_stream_insert_header_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;

  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;

  logic                    valid_insert;
  logic [DATA_WD-1:0]      data_insert;
  logic [DATA_BYTE_WD-1:0] keep_insert;
  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;
  logic                    ready_insert;

  modport slave (
    input  valid_in, data_in, keep_in, last_in,
    output ready_in,
    output valid_out, data_out, keep_out, last_out,
    input  ready_out,
    input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
    output ready_insert
  );

  modport master (
    output valid_in, data_in, keep_in, last_in,
    input  ready_in,
    input  valid_out, data_out, keep_out, last_out,
    output ready_out,
    output valid_insert, data_insert, keep_insert, byte_insert_cnt,
    input  ready_insert
  );
endinterface

// File: rtl/axi_stream_insert_header.sv
// AXI-Stream header inserter: prepends a 1..DATA_BYTE_WD byte header and re-packs the payload densely.
// Optional macro AXIS_INS_HDR_B2B_EN adds a second header slot so packets can follow back to back.
module axi_stream_insert_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input logic                       clk,
  input logic                       rst_n,
  axi_stream_insert_header_if.slave bus
);
  localparam int CW = BYTE_CNT_WD + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_FLUSH} state_t;

  state_t                  r_state;
  logic [DATA_WD-1:0]      r_res;
  logic [CW-1:0]           r_rcnt;
  logic [CW-1:0]           r_fcnt;
  logic                    r_valid_out;
  logic [DATA_WD-1:0]      r_data_out;
  logic [DATA_BYTE_WD-1:0] r_keep_out;
  logic                    r_last_out;

  function automatic logic [CW-1:0] popcnt(input logic [DATA_BYTE_WD-1:0] k);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) n = n + CW'(k[i]);
    return n;
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] top_keep(input logic [CW-1:0] n);
    return ~({DATA_BYTE_WD{1'b1}} >> n);
  endfunction

  function automatic logic [DATA_WD-1:0] low_mask(input logic [CW-1:0] n);
    return ~({DATA_WD{1'b1}} << {n, 3'b000});
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  logic                    w_ld, w_acc, w_hdr, w_single, w_end;
  logic [CW-1:0]           w_n, w_m, w_fcnt;
  logic [CW:0]             w_t;
  logic [DATA_WD-1:0]      w_hdr_res, w_beat, w_new_res, w_flush;
  logic [DATA_BYTE_WD-1:0] w_keep_single, w_keep_flush;

  assign w_ld     = !r_valid_out || bus.ready_out;
  assign w_acc    = (r_state == S_DATA) && bus.valid_in && w_ld;
  assign w_hdr    = bus.valid_insert && bus.ready_insert;
  assign w_n      = popcnt(bus.keep_insert);
  assign w_m      = popcnt(bus.keep_in);
  assign w_t      = {1'b0, r_rcnt} + {1'b0, w_m};
  assign w_single = (w_t <= (CW+1)'(DATA_BYTE_WD));
  assign w_fcnt   = CW'(w_t - (CW+1)'(DATA_BYTE_WD));

  // Residual lives in the low R bytes; the output beat is the top word of {residual, data_in}.
  assign w_hdr_res     = bus.data_insert & low_mask(w_n);
  assign w_beat        = DATA_WD'({r_res, bus.data_in} >> {r_rcnt, 3'b000});
  assign w_new_res     = bus.data_in & low_mask(r_rcnt);
  assign w_keep_single = top_keep(w_t[CW-1:0]);
  assign w_keep_flush  = top_keep(r_fcnt);
  assign w_flush       = (r_res << {CW'(DATA_BYTE_WD) - r_rcnt, 3'b000}) & byte_mask(w_keep_flush);
  assign w_end         = (w_acc && bus.last_in && w_single) || ((r_state == S_FLUSH) && w_ld);

`ifdef AXIS_INS_HDR_B2B_EN
  logic               r_hs_vld;
  logic [DATA_WD-1:0] r_hs_res;
  logic [CW-1:0]      r_hs_cnt;
  logic               w_take;

  assign bus.ready_insert = !r_hs_vld;
  assign w_take           = r_hs_vld && ((r_state == S_IDLE) || w_end);
`else
  assign bus.ready_insert = (r_state == S_IDLE);
`endif

  assign bus.ready_in  = (r_state == S_DATA) && w_ld;
  assign bus.valid_out = r_valid_out;
  assign bus.data_out  = r_data_out;
  assign bus.keep_out  = r_keep_out;
  assign bus.last_out  = r_last_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_res       <= '0;
      r_rcnt      <= '0;
      r_fcnt      <= '0;
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_keep_out  <= '0;
      r_last_out  <= 1'b0;
`ifdef AXIS_INS_HDR_B2B_EN
      r_hs_vld    <= 1'b0;
      r_hs_res    <= '0;
      r_hs_cnt    <= '0;
`endif
    end else begin
      if (w_ld) r_valid_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
`ifndef AXIS_INS_HDR_B2B_EN
          if (w_hdr) begin
            r_res   <= w_hdr_res;
            r_rcnt  <= w_n;
            r_state <= S_DATA;
          end
`endif
        end
        S_DATA: begin
          if (w_acc) begin
            r_valid_out <= 1'b1;
            r_res       <= w_new_res;
            if (!bus.last_in) begin
              r_data_out <= w_beat;
              r_keep_out <= '1;
              r_last_out <= 1'b0;
            end else if (w_single) begin
              r_data_out <= w_beat & byte_mask(w_keep_single);
              r_keep_out <= w_keep_single;
              r_last_out <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_data_out <= w_beat;
              r_keep_out <= '1;
              r_last_out <= 1'b0;
              r_fcnt     <= w_fcnt;
              r_state    <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (w_ld) begin
            r_valid_out <= 1'b1;
            r_data_out  <= w_flush;
            r_keep_out  <= w_keep_flush;
            r_last_out  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef AXIS_INS_HDR_B2B_EN
      // A queued header starts the next packet on the same edge the current one ends.
      if (w_take) begin
        r_res    <= r_hs_res;
        r_rcnt   <= r_hs_cnt;
        r_state  <= S_DATA;
        r_hs_vld <= 1'b0;
      end else if (w_hdr) begin
        r_hs_vld <= 1'b1;
        r_hs_res <= w_hdr_res;
        r_hs_cnt <= w_n;
      end
`endif
    end
  end

  a_hdr_cnt: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.valid_insert && bus.ready_insert) |-> (w_n[BYTE_CNT_WD-1:0] == bus.byte_insert_cnt));

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Directed bench for axi_stream_insert_header: a packet table with hand-computed output beats,
// plus backpressure, mid-packet reset and (with AXIS_INS_HDR_B2B_EN) back-to-back sequences.
module tb_axi_stream_insert_header;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  axi_stream_insert_header_if #(.DATA_WD(32)) b ();
  axi_stream_insert_header #(.DATA_WD(32)) dut (.clk(clk), .rst_n(rst_n), .bus(b));

  typedef struct {
    logic [31:0]       hdr;
    logic [3:0]        hk;
    int                nin;
    logic [0:2][31:0]  din;
    logic [0:2][3:0]   kin;
    int                nout;
    logic [0:3][31:0]  dout;
    logic [0:3][3:0]   kout;
    logic [0:3]        lout;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic [31:0] hdr, input logic [3:0] hk, input int nin,
                              input logic [0:2][31:0] din, input logic [0:2][3:0] kin,
                              input int nout, input logic [0:3][31:0] dout,
                              input logic [0:3][3:0] kout, input logic [0:3] lout);
    vec_t v;
    v.hdr = hdr; v.hk = hk; v.nin = nin; v.din = din; v.kin = kin;
    v.nout = nout; v.dout = dout; v.kout = kout; v.lout = lout;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask

  task automatic send_hdr(input logic [31:0] h, input logic [3:0] k);
    int w = 0;
    bit done = 1'b0;
    while (!done && w < 50) begin
      @(negedge clk);
      b.valid_insert    = 1'b1;
      b.data_insert     = h;
      b.keep_insert     = k;
      b.byte_insert_cnt = 2'($countones(k));
      #1;
      done = b.ready_insert;
      w++;
      @(posedge clk);
    end
    @(negedge clk);
    b.valid_insert = 1'b0;
    if (!done) begin
      n_chk++;
      $display("FAIL hdr_handshake: ready_insert low for %0d cycles, required a handshake", w);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int w = 0;
    bit done = 1'b0;
    while (!done && w < 50) begin
      @(negedge clk);
      b.valid_in = 1'b1;
      b.data_in  = d;
      b.keep_in  = k;
      b.last_in  = l;
      #1;
      done = b.ready_in;
      w++;
      @(posedge clk);
    end
    if (!done) begin
      n_chk++;
      $display("FAIL beat_handshake: ready_in low for %0d cycles, required a handshake", w);
    end
  endtask

  // ready_out is driven at the falling edge; outputs are sampled 2 ns later.
  task automatic mon(input vec_t v, input bit stall, output int c_first, output int c_last);
    int idx = 0, cyc = 0, stall_left = 0;
    bit stalled = 1'b0;
    logic [31:0] hd;
    logic [3:0]  hk;
    logic        hl;
    c_first = -1;
    c_last  = -1;
    while (idx < v.nout && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (stall && !stalled && idx == 1 && b.valid_out) begin
        stalled    = 1'b1;
        stall_left = 3;
        hd = b.data_out; hk = b.keep_out; hl = b.last_out;
      end
      if (stall_left > 0) begin
        b.ready_out = 1'b0;
        stall_left--;
        #2;
        chk("stall_data", b.data_out, hd);
        chk("stall_keep", 32'(b.keep_out), 32'(hk));
        chk("stall_last", 32'(b.last_out), 32'(hl));
        chk("stall_ready_in", 32'(b.ready_in), 32'd0);
      end else begin
        b.ready_out = 1'b1;
        #2;
        if (b.valid_out) begin
          chk($sformatf("out%0d_data", idx), b.data_out, v.dout[idx]);
          chk($sformatf("out%0d_keep", idx), 32'(b.keep_out), 32'(v.kout[idx]));
          chk($sformatf("out%0d_last", idx), 32'(b.last_out), 32'(v.lout[idx]));
          if (c_first < 0) c_first = cyc;
          c_last = cyc;
          idx++;
        end
      end
    end
    b.ready_out = 1'b1;
    if (idx < v.nout) begin
      n_chk++;
      $display("FAIL out_beats: got %0d beats, required %0d", idx, v.nout);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit stall);
    int c0, c1;
    fork
      begin
        send_hdr(v.hdr, v.hk);
        for (int j = 0; j < v.nin; j++) send_beat(v.din[j], v.kin[j], j == v.nin - 1);
        @(negedge clk);
        b.valid_in = 1'b0;
      end
      mon(v, stall, c0, c1);
    join
    @(negedge clk);
    #2;
    chk("idle_valid_out", 32'(b.valid_out), 32'd0);
    chk("idle_ready_in", 32'(b.ready_in), 32'd0);
    chk("idle_ready_insert", 32'(b.ready_insert), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid_out"}, 32'(b.valid_out), 32'd0);
    chk({tag, "_data_out"}, b.data_out, 32'd0);
    chk({tag, "_keep_out"}, 32'(b.keep_out), 32'd0);
    chk({tag, "_last_out"}, 32'(b.last_out), 32'd0);
    chk({tag, "_ready_in"}, 32'(b.ready_in), 32'd0);
    chk({tag, "_ready_insert"}, 32'(b.ready_insert), 32'd1);
  endtask

  initial begin
    vecs[0] = mk(32'h56245241, 4'hF, 1, {32'h514c845a, 32'h0, 32'h0}, {4'hF, 4'h0, 4'h0},
                 2, {32'h56245241, 32'h514c845a, 32'h0, 32'h0}, {4'hF, 4'hF, 4'h0, 4'h0}, 4'b0100);
    vecs[1] = mk(32'h0000A1B2, 4'h3, 2, {32'h11223344, 32'h55667788, 32'h0}, {4'hF, 4'hC, 4'h0},
                 2, {32'hA1B21122, 32'h33445566, 32'h0, 32'h0}, {4'hF, 4'hF, 4'h0, 4'h0}, 4'b0100);
    vecs[2] = mk(32'h3377005A, 4'h1, 1, {32'h514c845a, 32'h0, 32'h0}, {4'hF, 4'h0, 4'h0},
                 2, {32'h5A514C84, 32'h5A000000, 32'h0, 32'h0}, {4'hF, 4'h8, 4'h0, 4'h0}, 4'b0100);
    vecs[3] = mk(32'h00C1C2C3, 4'h7, 2, {32'hAABBCCDD, 32'hEE000000, 32'h0}, {4'hF, 4'h8, 4'h0},
                 2, {32'hC1C2C3AA, 32'hBBCCDDEE, 32'h0, 32'h0}, {4'hF, 4'hF, 4'h0, 4'h0}, 4'b0100);
    vecs[4] = mk(32'h0000A1B2, 4'h3, 2, {32'h11223344, 32'h55667788, 32'h0}, {4'hF, 4'hF, 4'h0},
                 3, {32'hA1B21122, 32'h33445566, 32'h77880000, 32'h0}, {4'hF, 4'hF, 4'hC, 4'h0}, 4'b0010);
    vecs[5] = mk(32'h01020304, 4'hF, 1, {32'h0A123456, 32'h0, 32'h0}, {4'h8, 4'h0, 4'h0},
                 2, {32'h01020304, 32'h0A000000, 32'h0, 32'h0}, {4'hF, 4'h8, 4'h0, 4'h0}, 4'b0100);
    vecs[6] = mk(32'hABCDEFEE, 4'h1, 1, {32'h112233FF, 32'h0, 32'h0}, {4'hE, 4'h0, 4'h0},
                 1, {32'hEE112233, 32'h0, 32'h0, 32'h0}, {4'hF, 4'h0, 4'h0, 4'h0}, 4'b1000);
    vecs[7] = mk(32'h0000A1B2, 4'h3, 1, {32'h99887766, 32'h0, 32'h0}, {4'h8, 4'h0, 4'h0},
                 1, {32'hA1B29900, 32'h0, 32'h0, 32'h0}, {4'hE, 4'h0, 4'h0, 4'h0}, 4'b1000);
    vecs[8] = mk(32'h00112233, 4'h7, 3, {32'h44556677, 32'h8899AABB, 32'hCCDDEEFF}, {4'hF, 4'hF, 4'hC},
                 4, {32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDD000000}, {4'hF, 4'hF, 4'hF, 4'h8}, 4'b0001);

    b.valid_in = 1'b0; b.data_in = '0; b.keep_in = '0; b.last_in = 1'b0;
    b.ready_out = 1'b1;
    b.valid_insert = 1'b0; b.data_insert = '0; b.keep_insert = '0; b.byte_insert_cnt = '0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], 1'b0);

    // Backpressure for 3 cycles while a payload beat is waiting.
    run_vec(vecs[8], 1'b1);

    // Reset while an output beat is pending and the packet is half transferred.
    send_hdr(32'h00112233, 4'h7);
    send_beat(32'h44556677, 4'hF, 1'b0);
    @(negedge clk);
    b.valid_in = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(vecs[1], 1'b0);

`ifdef AXIS_INS_HDR_B2B_EN
    begin
      vec_t v2;
      int c0, c1;
      v2 = mk(32'h0000A1B2, 4'h3, 2, {32'h11223344, 32'h55667788, 32'h0}, {4'hF, 4'hC, 4'h0},
              4, {32'hA1B21122, 32'h33445566, 32'hA1B21122, 32'h33445566},
              {4'hF, 4'hF, 4'hF, 4'hF}, 4'b0101);
      fork
        begin
          send_hdr(32'h0000A1B2, 4'h3);
          send_hdr(32'h0000A1B2, 4'h3);
        end
        begin
          send_beat(32'h11223344, 4'hF, 1'b0);
          send_beat(32'h55667788, 4'hC, 1'b1);
          send_beat(32'h11223344, 4'hF, 1'b0);
          send_beat(32'h55667788, 4'hC, 1'b1);
          @(negedge clk);
          b.valid_in = 1'b0;
        end
        mon(v2, 1'b0, c0, c1);
      join
      chk("b2b_gapless_span", 32'(c1 - c0), 32'd3);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
